// File: rtl/data_bus_controller.sv
// Single-outstanding CPU data-access sequencer onto a valid/ready memory bus.
// Define DATA_BUS_TIMEOUT_EN to build the BUSY-state abort counter (TIMEOUT_CYCLES).
module data_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_wstrobe,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_wstrobe,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_t;

  state_t state;
  logic   timeout_hit;

  assign req_ready = (state == IDLE);

`ifdef DATA_BUS_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] timer;

  // Abort on the BUSY cycle whose missing mem_ready would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
    end else if (state == BUSY && !mem_ready) begin
      timer <= timer + 1'b1;
    end
  end
`else
  // No abort path; the expression only keeps the parameter referenced.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // NOTE: all state and outputs below are registers, so every assignment is
  // non-blocking; a blocking '=' here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_valid   <= 1'b0;
      mem_address <= '0;
      mem_wstrobe <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_write && req_wstrobe == 4'b0000) begin
              // Empty store: nothing to put on the bus, answer straight away.
              rsp_valid <= 1'b1;
              rsp_error <= 1'b0;
              state     <= RESPOND;
            end else begin
              mem_address <= req_address & ~32'h3;
              mem_wstrobe <= req_write ? req_wstrobe : 4'b0000;
              mem_wdata   <= req_wdata;
              mem_valid   <= 1'b1;
              state       <= BUSY;
            end
          end
        end

        BUSY: begin
          if (mem_ready) begin
            // Loads are the only BUSY transactions with an all-zero strobe.
            if (mem_wstrobe == 4'b0000) begin
              rsp_rdata <= mem_rdata;
            end
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            state     <= RESPOND;
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESPOND;
          end
        end

        RESPOND: begin
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          mem_valid <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_controller.sv
// Transaction-level bench for data_bus_controller: directed and random accesses
// checked against expected bus/response timelines; timeout cases need DATA_BUS_TIMEOUT_EN.
module tb_data_bus_controller;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [3:0]  req_wstrobe;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [3:0]  mem_wstrobe;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          hs_cycle = 0;
  logic [31:0] model_rdata;

  data_bus_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wstrobe (req_wstrobe),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_address (mem_address),
    .mem_wstrobe (mem_wstrobe),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; called and returning at a falling edge.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input int delay, input bit hold_valid,
                        input bit expect_timeout, input logic [31:0] rdata);
    int   waited = 0;
    logic [3:0] exp_strb = wr ? strb : 4'b0000;
    bit   no_bus = wr && (strb == 4'b0000);
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_wstrobe = strb;
    req_wdata   = data;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    hs_cycle = cycle;
    @(negedge clk);
    if (!hold_valid) req_valid = 1'b0;
    if (no_bus) begin
      check("nobus_mem_valid", 32'(mem_valid), 32'd0);
    end else begin
      for (int k = 0; k <= delay; k++) begin
        check("busy_mem_valid", 32'(mem_valid), 32'd1);
        check("busy_address", mem_address, {addr[31:2], 2'b00});
        check("busy_wstrobe", 32'(mem_wstrobe), 32'(exp_strb));
        check("busy_wdata", mem_wdata, data);
        check("busy_req_ready", 32'(req_ready), 32'd0);
        check("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        mem_ready = (k == delay) && !expect_timeout;
        mem_rdata = (k == delay) ? rdata : $urandom;
        @(negedge clk);
      end
      check("resp_mem_valid", 32'(mem_valid), 32'd0);
    end
    if (expect_timeout) model_rdata = 32'h0;
    else if (!wr) model_rdata = rdata;
    // Bus acknowledge during RESPOND must be ignored.
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_error", 32'(rsp_error), 32'(expect_timeout));
    check("resp_rdata", rsp_rdata, model_rdata);
    check("resp_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rdata_hold", rsp_rdata, model_rdata);
  endtask

  initial begin
    int prev_hs;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_wstrobe = '0;
    req_wdata   = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    model_rdata = '0;
    #1;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wstrobe", 32'(mem_wstrobe), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: load with immediate acknowledge.
    access(1'b0, 32'h0000_1003, 4'b0000, 32'h0, 0, 1'b0, 1'b0, 32'hA1B2_C3D4);
    // Directed: store with acknowledge delayed 4 cycles; read word must not change.
    access(1'b1, 32'h0000_2002, 4'b1100, 32'h55AA_55AA, 4, 1'b0, 1'b0, 32'hDEAD_BEEF);
    // Directed: empty store never touches the bus.
    access(1'b1, 32'h0000_3000, 4'b0000, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0);

    // Acknowledge while idle must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      check("idle_ack_mem_valid", 32'(mem_valid), 32'd0);
      check("idle_ack_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_ack_rdata", rsp_rdata, model_rdata);
    end
    mem_ready = 1'b0;

    // Back-to-back loads with req_valid held high: one access every 3 cycles.
    access(1'b0, $urandom, 4'b0000, 32'h0, 0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) begin
      prev_hs = hs_cycle;
      access(1'b0, $urandom, 4'b0000, 32'h0, 0, 1'b1, 1'b0, $urandom);
      check("b2b_spacing", 32'(hs_cycle - prev_hs), 32'd3);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset asserted in the middle of a BUSY wait.
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = 32'h0000_4444;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_reset_mem_valid", 32'(mem_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_mem_valid", 32'(mem_valid), 32'd0);
    check("async_reset_req_ready", 32'(req_ready), 32'd1);
    model_rdata = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      check("after_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("after_reset_mem_valid", 32'(mem_valid), 32'd0);
    end
    mem_ready = 1'b0;
    access(1'b0, 32'h0000_5001, 4'b0000, 32'h0, 1, 1'b0, 1'b0, 32'hCAFE_F00D);

    // Acknowledge arriving on the last BUSY cycle before a would-be timeout.
    access(1'b0, 32'h0000_6000, 4'b0000, 32'h0, TO - 1, 1'b0, 1'b0, 32'h0BAD_C0DE);
`ifdef DATA_BUS_TIMEOUT_EN
    access(1'b0, 32'h0000_7000, 4'b0000, 32'h0, TO - 1, 1'b0, 1'b1, 32'h0);
    access(1'b1, 32'h0000_7004, 4'b0011, 32'h0F0F_0F0F, TO - 1, 1'b0, 1'b1, 32'h0);
`endif

    // Randomized mix of loads, stores and empty stores.
    for (int i = 0; i < 25; i++) begin
      bit         wr   = 1'($urandom_range(0, 1));
      logic [3:0] strb = 4'($urandom_range(0, 15));
      access(wr, $urandom, strb, $urandom, $urandom_range(0, 5), 1'b0, 1'b0, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
